// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first, one bit per clock, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the sub port and a - b (two's complement) mode.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q,      c_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             carry_q,  carry_d;

  logic             sub_sel;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Full add of the current bit pair from two half-adder cells plus the carry flop.
  logic ha0_s, ha0_c, ha1_c, bit_s, bit_c;
  assign ha0_s = a_sh_q[0] ^ b_sh_q[0];
  assign ha0_c = a_sh_q[0] & b_sh_q[0];
  assign bit_s = ha0_s ^ c_q;
  assign ha1_c = ha0_s & c_q;
  assign bit_c = ha0_c | ha1_c;

  logic [WIDTH-1:0] sum_shifted;
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shifted = bit_s;
    end else begin : g_wn
      assign sum_shifted = {bit_s, sum_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    carry_d  = carry_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_RUN;
          a_sh_d   = a;
          b_sh_d   = sub_sel ? ~b : b;
          sum_sh_d = '0;
          c_d      = sub_sel;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        sum_sh_d = sum_shifted;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        c_d      = bit_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          sum_d   = sum_shifted;
          carry_d = bit_c;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule
